// File: rtl/wb_mem_arbiter_if.sv
// Bus bundle between the two CPU Wishbone ports, the arbiter and the memory controller.
//
// Signal names are taken from the arbiter's point of view: *_i enters the arbiter and
// *_o leaves it.
//   m0_* : data-memory master port      (cyc/stb/we/addr/sel/data in, data/ack/err out)
//   m1_* : instruction-fetch master port (same set as m0_*)
//   s_*  : memory slave port            (cyc/stb/we/addr/sel/data out, data/ack in)
//
// Modports:
//   slave  - the arbiter. It is the Wishbone slave of both CPU ports and drives the
//            memory port.
//   master - the surrounding environment (CPU ports plus memory controller). It drives
//            every *_i signal and observes every *_o signal.
interface wb_mem_arbiter_if;

  // Master 0 (data memory)
  logic        m0_cyc_i;
  logic        m0_stb_i;
  logic        m0_we_i;
  logic [31:0] m0_addr_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_data_i;
  logic [31:0] m0_data_o;
  logic        m0_ack_o;
  logic        m0_err_o;

  // Master 1 (instruction fetch)
  logic        m1_cyc_i;
  logic        m1_stb_i;
  logic        m1_we_i;
  logic [31:0] m1_addr_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_data_i;
  logic [31:0] m1_data_o;
  logic        m1_ack_o;
  logic        m1_err_o;

  // Memory slave
  logic        s_cyc_o;
  logic        s_stb_o;
  logic        s_we_o;
  logic [31:0] s_addr_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_data_o;
  logic [31:0] s_data_i;
  logic        s_ack_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_sel_i, m0_data_i,
    output m0_data_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_sel_i, m1_data_i,
    output m1_data_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_sel_o, s_data_o,
    input  s_data_i, s_ack_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_sel_i, m0_data_i,
    input  m0_data_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_sel_i, m1_data_i,
    input  m1_data_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_sel_o, s_data_o,
    output s_data_i, s_ack_i
  );

endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the board SSRAM/flash controller.
//
// Master 0 is the data-memory port, master 1 the instruction-fetch port. One master is
// granted at a time; on a tie the master that did not complete last wins. Every slave
// transaction is followed by at least one GAP cycle with cyc/stb low, because the memory
// controller starts an access on the rising edge of its request. A watchdog ends any
// access the slave leaves unacknowledged for TIMEOUT cycles with an error to the master.
//
// Ports:
//   clk_i    - system clock, rising-edge active
//   rst_n_i  - asynchronous active-low reset
//   bus      - wb_mem_arbiter_if.slave bundle (both master ports and the slave port)
//
// Parameters:
//   TIMEOUT  - BUSY cycles without s_ack_i before the access is aborted (2..255)
module wb_mem_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  wb_mem_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StGap
  } state_e;

  // Watchdog count reached in the last permitted BUSY cycle.
  localparam logic [7:0] TcntLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;
  logic [7:0] tcnt_q, tcnt_d;

  logic req0, req1;
  logic arb_req;
  logic arb_pick;
  logic gnt_req;
  logic busy;
  logic fwd_ack;
  logic fwd_err;

  assign req0     = bus.m0_cyc_i & bus.m0_stb_i;
  assign req1     = bus.m1_cyc_i & bus.m1_stb_i;
  assign arb_req  = req0 | req1;
  // Tie goes to the master that did not complete last; otherwise the lone requester.
  assign arb_pick = (req0 & req1) ? ~last_q : req1;
  assign gnt_req  = gnt_q ? req1 : req0;
  assign busy     = (state_q == StBusy);

  // An abort (granted master dropping its request) masks both ack and timeout.
  assign fwd_ack = busy & gnt_req & bus.s_ack_i;
  assign fwd_err = busy & gnt_req & ~bus.s_ack_i & (tcnt_q == TcntLast);

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      StIdle, StGap: begin
        if (arb_req) begin
          state_d = StBusy;
          gnt_d   = arb_pick;
          tcnt_d  = 8'd0;
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        // Exit at TcntLast <= 254 happens before this can wrap.
        tcnt_d = tcnt_q + 8'd1;
        if (!gnt_req) begin
          state_d = StGap;
        end else if (bus.s_ack_i) begin
          state_d = StGap;
          last_d  = gnt_q;
        end else if (tcnt_q == TcntLast) begin
          state_d = StGap;
          last_d  = gnt_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic; the slave port follows the granted master only while BUSY.
  always_comb begin
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.s_we_o   = 1'b0;
    bus.s_addr_o = 32'd0;
    bus.s_sel_o  = 4'd0;
    bus.s_data_o = 32'd0;
    if (busy) begin
      bus.s_cyc_o  = 1'b1;
      bus.s_stb_o  = 1'b1;
      bus.s_we_o   = gnt_q ? bus.m1_we_i   : bus.m0_we_i;
      bus.s_addr_o = gnt_q ? bus.m1_addr_i : bus.m0_addr_i;
      bus.s_sel_o  = gnt_q ? bus.m1_sel_i  : bus.m0_sel_i;
      bus.s_data_o = gnt_q ? bus.m1_data_i : bus.m0_data_i;
    end

    // Read data is broadcast; each master qualifies it with its own ack.
    bus.m0_data_o = bus.s_data_i;
    bus.m1_data_o = bus.s_data_i;

    bus.m0_ack_o = fwd_ack & ~gnt_q;
    bus.m1_ack_o = fwd_ack &  gnt_q;
    bus.m0_err_o = fwd_err & ~gnt_q;
    bus.m1_err_o = fwd_err &  gnt_q;
  end

endmodule
